// File: rtl/mid_side_stream.sv
// Streaming mid/side processor: bypass, M/S encode, M/S decode and stereo width.
// Three-stage valid/ready pipeline with saturating outputs and a sticky clip flag.
module mid_side_stream #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic [GAIN_W-1:0]        side_gain,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_a,
    input  logic signed [DATA_W-1:0] s_b,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_a,
    output logic signed [DATA_W-1:0] m_b,
    input  logic                     clip_clr,
    output logic                     clip_sticky
);

    localparam int W  = DATA_W + GAIN_W + 2;
    localparam int SW = DATA_W + 1;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_ENCODE = 2'b01;
    localparam logic [1:0] MODE_DECODE = 2'b10;
    localparam logic [1:0] MODE_WIDTH  = 2'b11;

    localparam logic signed [W-1:0] MAX_W = {{(W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W = {{(W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Valid/ready: a beat moves on either side when valid && ready at a rising
    // edge. The whole pipeline advances as one unit whenever the output register
    // is empty or being drained, so s_ready is exactly that advance condition.
    logic adv;
    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

    // Stage 1 registers
    logic                     v1;
    logic [1:0]               mode1;
    logic [GAIN_W-1:0]        gain1;
    logic signed [DATA_W-1:0] a1;
    logic signed [DATA_W-1:0] b1;
    logic signed [SW-1:0]     sum1;
    logic signed [SW-1:0]     diff1;

    // Stage 2 registers
    logic                     v2;
    logic [1:0]               mode2;
    logic signed [W-1:0]      x2;
    logic signed [W-1:0]      y2;

    logic signed [SW-1:0] in_sum;
    logic signed [SW-1:0] in_diff;
    assign in_sum  = $signed({s_a[DATA_W-1], s_a}) + $signed({s_b[DATA_W-1], s_b});
    assign in_diff = $signed({s_a[DATA_W-1], s_a}) - $signed({s_b[DATA_W-1], s_b});

    logic signed [SW-1:0] half_sum;
    logic signed [SW-1:0] half_diff;
    logic signed [W-1:0]  side_prod;
    logic signed [W-1:0]  side_scaled;
    logic signed [W-1:0]  x2_next;
    logic signed [W-1:0]  y2_next;

    assign half_sum  = sum1 >>> 1;
    assign half_diff = diff1 >>> 1;
    // |S| * gain stays below 2^(W-3), so the W-bit product never wraps.
    assign side_prod   = $signed({{(W-SW){half_diff[SW-1]}}, half_diff})
                       * $signed({{(W-GAIN_W){1'b0}}, gain1});
    assign side_scaled = side_prod >>> (GAIN_W - 2);

    always_comb begin
        x2_next = {{(W-DATA_W){a1[DATA_W-1]}}, a1};
        y2_next = {{(W-DATA_W){b1[DATA_W-1]}}, b1};
        case (mode1)
            MODE_ENCODE: begin
                x2_next = {{(W-SW){half_sum[SW-1]}}, half_sum};
                y2_next = {{(W-SW){half_diff[SW-1]}}, half_diff};
            end
            MODE_DECODE: begin
                x2_next = {{(W-SW){sum1[SW-1]}}, sum1};
                y2_next = {{(W-SW){diff1[SW-1]}}, diff1};
            end
            MODE_WIDTH: begin
                x2_next = {{(W-SW){half_sum[SW-1]}}, half_sum};
                y2_next = side_scaled;
            end
            default: begin
                x2_next = {{(W-DATA_W){a1[DATA_W-1]}}, a1};
                y2_next = {{(W-DATA_W){b1[DATA_W-1]}}, b1};
            end
        endcase
    end

    logic signed [W-1:0]      l_full;
    logic signed [W-1:0]      r_full;
    logic signed [DATA_W-1:0] out_a;
    logic signed [DATA_W-1:0] out_b;
    logic                     sat_l;
    logic                     sat_r;
    logic                     clip_hit;

    always_comb begin
        l_full = x2;
        r_full = y2;
        if (mode2 == MODE_WIDTH) begin
            l_full = x2 + y2;
            r_full = x2 - y2;
        end
        sat_l = 1'b0;
        sat_r = 1'b0;
        out_a = l_full[DATA_W-1:0];
        out_b = r_full[DATA_W-1:0];
        // Bypass values are already in range; only the arithmetic modes clamp.
        if (mode2 != MODE_BYPASS) begin
            if (l_full > MAX_W) begin
                out_a = MAX_W[DATA_W-1:0];
                sat_l = 1'b1;
            end else if (l_full < MIN_W) begin
                out_a = MIN_W[DATA_W-1:0];
                sat_l = 1'b1;
            end
            if (r_full > MAX_W) begin
                out_b = MAX_W[DATA_W-1:0];
                sat_r = 1'b1;
            end else if (r_full < MIN_W) begin
                out_b = MIN_W[DATA_W-1:0];
                sat_r = 1'b1;
            end
        end
        clip_hit = v2 && (sat_l || sat_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            mode1       <= '0;
            gain1       <= '0;
            a1          <= '0;
            b1          <= '0;
            sum1        <= '0;
            diff1       <= '0;
            v2          <= 1'b0;
            mode2       <= '0;
            x2          <= '0;
            y2          <= '0;
            m_valid     <= 1'b0;
            m_a         <= '0;
            m_b         <= '0;
            clip_sticky <= 1'b0;
        end else begin
            if (adv) begin
                v1      <= s_valid;
                mode1   <= mode;
                gain1   <= side_gain;
                a1      <= s_a;
                b1      <= s_b;
                sum1    <= in_sum;
                diff1   <= in_diff;
                v2      <= v1;
                mode2   <= mode1;
                x2      <= x2_next;
                y2      <= y2_next;
                m_valid <= v2;
                m_a     <= out_a;
                m_b     <= out_b;
            end
            // A new clip event wins over a simultaneous clear.
            if (adv && clip_hit) begin
                clip_sticky <= 1'b1;
            end else if (clip_clr) begin
                clip_sticky <= 1'b0;
            end
        end
    end

endmodule
